tile_sequencer: RTL and testbench



---
 rtl/tile_seq_pkg.sv | 32 +++
 rtl/tile_addr_gen.sv | 88 ++++++++
 rtl/tile_sequencer.sv | 135 +++++++++++++
 tb/tb_tile_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tile_seq_pkg.sv
// tile_seq_pkg: shared types for the tile sequencer.
//   - FSM state encodings (legacy 3-bit constants) plus a matching enum type
//   - tile_cfg_t: latched layer-pass configuration
// The struct field widths are fixed by TS_DIM_W / TS_ADDR_W. Any instance that
// overrides DIM_W / ADDR_W must keep them equal to these.
package tile_seq_pkg;
   localparam int TS_DIM_W  = 12;
   localparam int TS_ADDR_W = 16;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT_ACK  = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_DRAIN     = 3'd4;
   localparam logic [2:0] S_FINISH    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_ISSUE     = S_ISSUE,
      ST_WAIT_ACK  = S_WAIT_ACK,
      ST_WAIT_DONE = S_WAIT_DONE,
      ST_DRAIN     = S_DRAIN,
      ST_FINISH    = S_FINISH
   } ts_state_e;

   typedef struct packed {
      logic [TS_DIM_W-1:0]  k_tiles;
      logic [TS_DIM_W-1:0]  n_tiles;
      logic [TS_ADDR_W-1:0] w_base;
      logic [TS_ADDR_W-1:0] if_base;
   } tile_cfg_t;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: K/N tile counters, last-tile flags and per-tile base addresses.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i, cfg_i     latch a new configuration and restart at tile (0,0)
//   step_k_i          advance to the next K tile of the current N tile
//   step_n_i          advance to K tile 0 of the next N tile
//   k_last_o/n_last_o current tile is the last K / last N tile
//   acc_en_o          0 on the first K tile (clear psums), 1 otherwise
//   w_addr_o/if_addr_o weight / ifmap base for the current tile
module tile_addr_gen import tile_seq_pkg::*; #(
   parameter int SYS_H         = 8,
   parameter int IF_TILE_WORDS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 step_k_i,
   input  logic                 step_n_i,
   input  tile_cfg_t            cfg_i,
   output logic                 k_last_o,
   output logic                 n_last_o,
   output logic                 acc_en_o,
   output logic [TS_ADDR_W-1:0] w_addr_o,
   output logic [TS_ADDR_W-1:0] if_addr_o
);
   localparam logic [TS_ADDR_W-1:0] W_STEP  = TS_ADDR_W'(SYS_H);
   localparam logic [TS_ADDR_W-1:0] IF_STEP = TS_ADDR_W'(IF_TILE_WORDS);
   localparam logic [TS_DIM_W-1:0]  DIM_ONE = TS_DIM_W'(1);

   tile_cfg_t            cfg_q, cfg_d;
   logic [TS_DIM_W-1:0]  k_q, k_d, n_q, n_d;
   logic [TS_ADDR_W-1:0] w_q, w_d, if_q, if_d;
   logic                 acc_q, acc_d;

   always_comb begin
      cfg_d = cfg_q;
      k_d   = k_q;
      n_d   = n_q;
      w_d   = w_q;
      if_d  = if_q;
      acc_d = acc_q;
      if (load_i) begin
         cfg_d = cfg_i;
         k_d   = '0;
         n_d   = '0;
         w_d   = cfg_i.w_base;
         if_d  = cfg_i.if_base;
         acc_d = 1'b0;
      end else if (step_k_i) begin
         k_d   = k_q + DIM_ONE;
         w_d   = w_q + W_STEP;
         if_d  = if_q + IF_STEP;
         acc_d = 1'b1;
      end else if (step_n_i) begin
         // weights for successive N tiles are laid out back to back, so the
         // weight base keeps walking while the ifmap base rewinds
         n_d   = n_q + DIM_ONE;
         k_d   = '0;
         w_d   = w_q + W_STEP;
         if_d  = cfg_q.if_base;
         acc_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q <= '0;
         k_q   <= '0;
         n_q   <= '0;
         w_q   <= '0;
         if_q  <= '0;
         acc_q <= 1'b0;
      end else begin
         cfg_q <= cfg_d;
         k_q   <= k_d;
         n_q   <= n_d;
         w_q   <= w_d;
         if_q  <= if_d;
         acc_q <= acc_d;
      end
   end

   assign k_last_o  = (k_q == (cfg_q.k_tiles - DIM_ONE));
   assign n_last_o  = (n_q == (cfg_q.n_tiles - DIM_ONE));
   assign acc_en_o  = acc_q;
   assign w_addr_o  = w_q;
   assign if_addr_o = if_q;
endmodule

// File: rtl/tile_sequencer.sv
// tile_sequencer: runs one layer pass as n_tiles x k_tiles array tiles.
// For every tile it hands the array controller a start pulse plus the weight
// and ifmap bases, and after the last K tile of each N tile requests a drain.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      config handshake (ready only while idle)
//   cfg_k_tiles/cfg_n_tiles  tile counts; either zero finishes immediately
//   cfg_w_base/cfg_if_base   buffer bases for tile (0,0)
//   arr_start/arr_ready      one-cycle start / controller idle
//   w_addr_base/if_addr_base per-tile bases, acc_en psum accumulate select
//   drain_req/drain_done     output writeback request / completion pulse
//   busy, done               not idle / end-of-pass pulse
//   stall_cycles             only with TILE_SEQ_STALL_CNT_EN: cycles spent
//                            waiting for the controller or draining
module tile_sequencer import tile_seq_pkg::*; #(
   parameter int SYS_H         = 8,
   parameter int IF_TILE_WORDS = 64,
   parameter int DIM_W         = TS_DIM_W,
   parameter int ADDR_W        = TS_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DIM_W-1:0]  cfg_k_tiles,
   input  logic [DIM_W-1:0]  cfg_n_tiles,
   input  logic [ADDR_W-1:0] cfg_w_base,
   input  logic [ADDR_W-1:0] cfg_if_base,
   output logic              arr_start,
   input  logic              arr_ready,
   output logic [ADDR_W-1:0] w_addr_base,
   output logic [ADDR_W-1:0] if_addr_base,
   output logic              acc_en,
   output logic              drain_req,
   input  logic              drain_done,
   output logic              busy,
   output logic              done
`ifdef TILE_SEQ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);
   logic [2:0] state_q, state_d;
   logic       load, step_k, step_n, k_last, n_last;
   logic       cfg_ready_q, arr_start_q, drain_req_q, busy_q, done_q;
   tile_cfg_t  cfg_in;

   assign cfg_in = '{k_tiles: cfg_k_tiles, n_tiles: cfg_n_tiles,
                     w_base: cfg_w_base, if_base: cfg_if_base};

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step_k  = 1'b0;
      step_n  = 1'b0;
      case (state_q)
         S_IDLE: if (cfg_valid) begin
            load    = 1'b1;
            state_d = (cfg_k_tiles == '0 || cfg_n_tiles == '0) ? S_FINISH : S_ISSUE;
         end
         S_ISSUE:     if (arr_ready) state_d = S_WAIT_ACK;
         // ready falling is the controller's acknowledge of the start
         S_WAIT_ACK:  if (!arr_ready) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (arr_ready) begin
            if (!k_last) begin
               step_k  = 1'b1;
               state_d = S_ISSUE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: if (drain_done) begin
            if (!n_last) begin
               step_n  = 1'b1;
               state_d = S_ISSUE;
            end else begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cfg_ready_q <= 1'b1;
         arr_start_q <= 1'b0;
         drain_req_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         arr_start_q <= (state_q == S_ISSUE) && arr_ready;
         drain_req_q <= (state_d == S_DRAIN);
         done_q      <= (state_q == S_FINISH);
      end
   end

   tile_addr_gen #(.SYS_H(SYS_H), .IF_TILE_WORDS(IF_TILE_WORDS)) u_addr (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .step_k_i  (step_k),
      .step_n_i  (step_n),
      .cfg_i     (cfg_in),
      .k_last_o  (k_last),
      .n_last_o  (n_last),
      .acc_en_o  (acc_en),
      .w_addr_o  (w_addr_base),
      .if_addr_o (if_addr_base)
   );

   assign cfg_ready = cfg_ready_q;
   assign arr_start = arr_start_q;
   assign drain_req = drain_req_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef TILE_SEQ_STALL_CNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if (state_q == S_IDLE && cfg_valid)
         stall_q <= '0;
      else if (((state_q == S_ISSUE && !arr_ready) || state_q == S_DRAIN) && stall_q != '1)
         stall_q <= stall_q + 32'd1;
   end
   assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_tile_sequencer.sv
module tb_tile_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [11:0] cfg_k_tiles = '0, cfg_n_tiles = '0;
   logic [15:0] cfg_w_base = '0, cfg_if_base = '0;
   logic        arr_start, arr_ready = 1'b1;
   logic [15:0] w_addr_base, if_addr_base;
   logic        acc_en, drain_req, drain_done = 1'b0, busy, done;
`ifdef TILE_SEQ_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   tile_sequencer dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles),
      .cfg_w_base(cfg_w_base), .cfg_if_base(cfg_if_base),
      .arr_start(arr_start), .arr_ready(arr_ready),
      .w_addr_base(w_addr_base), .if_addr_base(if_addr_base),
      .acc_en(acc_en), .drain_req(drain_req), .drain_done(drain_done),
      .busy(busy), .done(done)
`ifdef TILE_SEQ_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // controller / writeback models; window [hs, hs+hl) forces arr_ready low
   int dlat = 0, hs = 0, hl = 0;
   int bcnt = 0, dcnt = 0, dd_edge = 0;
   bit dpend = 0;
   initial forever begin
      @(negedge clk);
      if (arr_start) bcnt = 5;
      else if (bcnt > 0) bcnt--;
      arr_ready = (bcnt == 0) && !(cyc >= hs && cyc < hs + hl);
      drain_done = 1'b0;
      if (drain_req && !dpend) begin dpend = 1; dcnt = dlat; end
      if (dpend) begin
         if (dcnt == 0) begin drain_done = 1'b1; dpend = 0; dd_edge = cyc + 1; end
         else dcnt--;
      end
   end

   // monitor: cumulative counts and per-start logs
   int n_start = 0, n_drain = 0, n_drq = 0, n_done = 0, done_cyc = 0;
   int start_cyc [256];
   logic [15:0] log_w [256], log_if [256];
   logic log_acc [256];
   logic prev_drq = 1'b0;
   always @(negedge clk) begin
      if (arr_start && n_start < 256) begin
         start_cyc[n_start] = cyc;
         log_w[n_start] = w_addr_base;
         log_if[n_start] = if_addr_base;
         log_acc[n_start] = acc_en;
      end
      if (arr_start) n_start++;
      if (drain_req) n_drq++;
      if (drain_req && !prev_drq) n_drain++;
      prev_drq = drain_req;
      if (done) begin n_done++; done_cyc = cyc; end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int k, n;
      logic [15:0] wb, ib;
      int lat;
      int exp_starts, exp_drains;
   } vec_t;
   vec_t vecs [6];

   task automatic wait_done(input int o0, input string nm);
      int i;
      for (i = 0; i < 3000 && n_done == o0; i++) @(negedge clk);
      if (n_done == o0) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic run_pass(input vec_t v, input string nm);
      int s0, d0, q0, o0, acc_c;
      logic [15:0] ew, ei;
      s0 = n_start; d0 = n_drain; q0 = n_drq; o0 = n_done;
      dlat = v.lat;
      chk({nm, "_cfg_ready_pre"}, cfg_ready, 1);
      cfg_k_tiles = 12'(v.k); cfg_n_tiles = 12'(v.n);
      cfg_w_base = v.wb; cfg_if_base = v.ib; cfg_valid = 1'b1;
      @(negedge clk);
      acc_c = cyc;
      // scramble the config bus: the sequencer must use the latched copy
      cfg_valid = 1'b0; cfg_w_base = 16'hDEAD; cfg_if_base = 16'hBEEF;
      cfg_k_tiles = 12'd7; cfg_n_tiles = 12'd7;
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_cfg_ready_busy"}, cfg_ready, 0);
      wait_done(o0, nm);
      repeat (4) @(negedge clk);
      chk({nm, "_starts"}, n_start - s0, v.exp_starts);
      chk({nm, "_drains"}, n_drain - d0, v.exp_drains);
      chk({nm, "_drq_cycles"}, n_drq - q0, v.exp_drains * (v.lat + 1));
      chk({nm, "_dones"}, n_done - o0, 1);
      if (v.exp_starts > 0) chk({nm, "_start_lat"}, start_cyc[s0] - acc_c, 1);
      if (v.exp_drains == 0) chk({nm, "_done_lat_cfg"}, done_cyc - acc_c, 1);
      else chk({nm, "_done_lat_drain"}, done_cyc - dd_edge, 1);
      for (int j = 0; j < v.exp_starts && j < n_start - s0; j++) begin
         ew = v.wb + 16'(8 * j);
         ei = v.ib + 16'(64 * (j % v.k));
         chk($sformatf("%s_w%0d", nm, j), log_w[s0+j], ew);
         chk($sformatf("%s_if%0d", nm, j), log_if[s0+j], ei);
         chk($sformatf("%s_acc%0d", nm, j), log_acc[s0+j], (j % v.k) != 0);
      end
      chk({nm, "_idle_busy"}, busy, 0);
      chk({nm, "_idle_ready"}, cfg_ready, 1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_cfg_ready"}, cfg_ready, 1);
      chk({nm, "_arr_start"}, arr_start, 0);
      chk({nm, "_drain_req"}, drain_req, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_acc_en"}, acc_en, 0);
      chk({nm, "_w_addr"}, w_addr_base, 0);
      chk({nm, "_if_addr"}, if_addr_base, 0);
   endtask

   initial begin
      int s0, d0, q0, o0, st, i;
      vec_t rv;
      vecs[0] = '{k: 3, n: 2, wb: 16'h0100, ib: 16'h0400, lat: 0, exp_starts: 6, exp_drains: 2};
      vecs[1] = '{k: 1, n: 1, wb: 16'h0200, ib: 16'h0800, lat: 10, exp_starts: 1, exp_drains: 1};
      vecs[2] = '{k: 0, n: 4, wb: 16'h0300, ib: 16'h0900, lat: 0, exp_starts: 0, exp_drains: 0};
      vecs[3] = '{k: 2, n: 1, wb: 16'hFFF8, ib: 16'h0000, lat: 1, exp_starts: 2, exp_drains: 1};
      vecs[4] = '{k: 2, n: 3, wb: 16'h0010, ib: 16'hFFC0, lat: 2, exp_starts: 6, exp_drains: 3};
      vecs[5] = '{k: 4, n: 0, wb: 16'h0040, ib: 16'h0080, lat: 0, exp_starts: 0, exp_drains: 0};

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         run_pass(vecs[v], $sformatf("vec%0d", v));
         repeat (3) @(negedge clk);
      end

      // arr_ready held low for the first 20 ISSUE cycles
      s0 = n_start; o0 = n_done; dlat = 0;
      hs = cyc + 1; hl = 20;
      cfg_k_tiles = 12'd1; cfg_n_tiles = 12'd1;
      cfg_w_base = 16'h0500; cfg_if_base = 16'h0600; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("hold_window_start", cyc, hs);
      st = 0;
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (arr_start) st++;
      end
      chk("hold_no_start", st, 0);
      @(negedge clk);
      chk("hold_start_after", arr_start, 1);
`ifdef TILE_SEQ_STALL_CNT_EN
      chk("stall_issue", stall_cycles, 20);
`endif
      wait_done(o0, "hold");
      repeat (4) @(negedge clk);
      chk("hold_starts", n_start - s0, 1);
`ifdef TILE_SEQ_STALL_CNT_EN
      chk("stall_total_hold", stall_cycles, 21);
`endif
      hl = 0;
      repeat (3) @(negedge clk);

      // reset during WAIT_DONE of the second tile
      s0 = n_start; d0 = n_drain; q0 = n_drq;
      cfg_k_tiles = 12'd3; cfg_n_tiles = 12'd2;
      cfg_w_base = 16'h0700; cfg_if_base = 16'h0800; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      for (i = 0; i < 200 && n_start < s0 + 2; i++) @(negedge clk);
      chk("rst_reach_tile2", n_start - s0, 2);
      repeat (2) @(negedge clk);
      chk("rst_pre_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("midrst");
`ifdef TILE_SEQ_STALL_CNT_EN
      chk("midrst_stall", stall_cycles, 0);
`endif
      repeat (12) @(negedge clk);
      chk("midrst_no_start", n_start - s0, 2);
      chk("midrst_no_drain", n_drain - d0, 0);
      chk("midrst_no_drq", n_drq - q0, 0);
      chk("midrst_busy", busy, 0);
      rv = '{k: 2, n: 2, wb: 16'h1000, ib: 16'h2000, lat: 3, exp_starts: 4, exp_drains: 2};
      run_pass(rv, "postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
